// File: rtl/bcd_two_digit_counter.sv
// Two-digit BCD up/down event counter with prescaled count tick and a free-running
// scan divider that produces the ones/tens digit-select for a display mux.
module bcd_two_digit_counter #(
  parameter int COUNT_DIV = 100_000_000,
  parameter int SCAN_BITS = 18
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Enable,
  input  logic       Up_Down,
  input  logic       Clear,
  input  logic       Load,
  input  logic [3:0] Load_Ones,
  input  logic [3:0] Load_Tens,
  output logic [3:0] Ones_Counter,
  output logic [3:0] Tens_Counter,
  output logic       Select,
  output logic       Tick,
  output logic       Wrap
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0]        pre_q,  pre_d;
  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [3:0]           ones_q, ones_d;
  logic [3:0]           tens_q, tens_d;
  logic                 tick_q, tick_d;
  logic                 wrap_q, wrap_d;
  logic                 tick_now;

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  assign tick_now = Enable && (pre_q == PRE_MAX);

  always_comb begin
    scan_d = scan_q + SCAN_BITS'(1);
    pre_d  = pre_q;
    ones_d = ones_q;
    tens_d = tens_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;

    if (Enable)
      pre_d = tick_now ? '0 : pre_q + PW'(1);

    if (Clear) begin
      pre_d  = '0;
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (Load) begin
      // a tick landing on a load cycle is dropped; prescaler keeps running
      ones_d = clamp9(Load_Ones);
      tens_d = clamp9(Load_Tens);
    end else if (tick_now) begin
      tick_d = 1'b1;
      if (Up_Down) begin
        if (ones_q < 4'd9) begin
          ones_d = ones_q + 4'd1;
        end else begin
          ones_d = 4'd0;
          if (tens_q < 4'd9) begin
            tens_d = tens_q + 4'd1;
          end else begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        if (ones_q > 4'd0) begin
          ones_d = ones_q - 4'd1;
        end else begin
          ones_d = 4'd9;
          if (tens_q > 4'd0) begin
            tens_d = tens_q - 4'd1;
          end else begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pre_q  <= '0;
      scan_q <= '0;
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      scan_q <= scan_d;
      ones_q <= ones_d;
      tens_q <= tens_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign Ones_Counter = ones_q;
  assign Tens_Counter = tens_q;
  assign Select       = scan_q[SCAN_BITS-1];
  assign Tick         = tick_q;
  assign Wrap         = wrap_q;

endmodule

// File: tb/tb_bcd_two_digit_counter.sv
// Randomized and directed bench for bcd_two_digit_counter; reference model keeps the
// count as a plain 0..99 integer and the scan phase as an elapsed-cycle count.
module tb_bcd_two_digit_counter;

  localparam int DIV  = 4;
  localparam int SBIT = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Enable = 1'b0, Up_Down = 1'b1, Clear = 1'b0, Load = 1'b0;
  logic [3:0] Load_Ones = 4'd0, Load_Tens = 4'd0;
  logic [3:0] Ones_Counter, Tens_Counter;
  logic       Select, Tick, Wrap;

  int vectors = 0;
  int fails   = 0;

  // reference model state
  int m_cnt = 0, m_pre = 0, m_scan = 0;
  bit m_tick = 0, m_wrap = 0;

  bcd_two_digit_counter #(.COUNT_DIV(DIV), .SCAN_BITS(SBIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable), .Up_Down(Up_Down),
    .Clear(Clear), .Load(Load), .Load_Ones(Load_Ones), .Load_Tens(Load_Tens),
    .Ones_Counter(Ones_Counter), .Tens_Counter(Tens_Counter),
    .Select(Select), .Tick(Tick), .Wrap(Wrap)
  );

  always #5 Clk = ~Clk;

  wire [10:0] obs = {Tens_Counter, Ones_Counter, Tick, Wrap, Select};

  function automatic logic [10:0] expv();
    logic [3:0] t, o;
    logic       s;
    t = 4'(m_cnt / 10);
    o = 4'(m_cnt % 10);
    s = ((m_scan % (1 << SBIT)) >= (1 << (SBIT - 1)));
    return {t, o, m_tick, m_wrap, s};
  endfunction

  function automatic int clampv(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  // advance the model using the inputs present before the edge, then wait for the edge
  task automatic step();
    int n_cnt, n_pre, n_scan;
    bit n_tick, n_wrap, fire;
    n_cnt = m_cnt; n_pre = m_pre; n_scan = m_scan + 1; n_tick = 0; n_wrap = 0;
    fire = Enable && (m_pre == DIV - 1);
    if (!Reset_n) begin
      n_cnt = 0; n_pre = 0; n_scan = 0;
    end else if (Clear) begin
      n_cnt = 0; n_pre = 0;
    end else begin
      if (Enable) n_pre = (m_pre + 1) % DIV;
      if (Load) begin
        n_cnt = clampv(Load_Tens) * 10 + clampv(Load_Ones);
      end else if (fire) begin
        n_tick = 1;
        if (Up_Down) begin
          n_wrap = (m_cnt == 99);
          n_cnt  = (m_cnt + 1) % 100;
        end else begin
          n_wrap = (m_cnt == 0);
          n_cnt  = (m_cnt + 99) % 100;
        end
      end
    end
    @(posedge Clk);
    #1;
    m_cnt = n_cnt; m_pre = n_pre; m_scan = n_scan; m_tick = n_tick; m_wrap = n_wrap;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    step();
    step();
    vectors++;
    if (obs !== 11'd0) begin
      fails++;
      $display("FAIL reset: got %b want %b", obs, 11'd0);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_count_up();
    int ticks = 0;
    Enable = 1'b1; Up_Down = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL count_up cyc %0d: got %b want %b", i, obs, expv());
      end
      if (Tick) ticks++;
    end
    vectors++;
    if ({Tens_Counter, Ones_Counter, ticks} !== {4'd1, 4'd0, 32'd10}) begin
      fails++;
      $display("FAIL count_up_end: got %0d%0d ticks %0d want 10 ticks 10",
               Tens_Counter, Ones_Counter, ticks);
    end
  endtask

  task automatic test_wrap_up();
    Load = 1'b1; Load_Ones = 4'd9; Load_Tens = 4'd9; Up_Down = 1'b1;
    step();
    Load = 1'b0;
    for (int i = 0; i < 2 * DIV && !m_tick; i++) begin
      step();
      vectors++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL wrap_up cyc %0d: got %b want %b", i, obs, expv());
      end
    end
    vectors++;
    if ({Tens_Counter, Ones_Counter, Tick, Wrap} !== {4'd0, 4'd0, 2'b11}) begin
      fails++;
      $display("FAIL wrap_up_event: got %0d%0d t%b w%b want 00 t1 w1",
               Tens_Counter, Ones_Counter, Tick, Wrap);
    end
    step();
    vectors++;
    if ({Tick, Wrap} !== 2'b00) begin
      fails++;
      $display("FAIL wrap_up_pulse: got t%b w%b want t0 w0", Tick, Wrap);
    end
  endtask

  task automatic test_wrap_down();
    Load = 1'b1; Load_Ones = 4'd0; Load_Tens = 4'd0; Up_Down = 1'b0;
    step();
    Load = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 2 * DIV; i++) begin
        step();
        vectors++;
        if (obs !== expv()) begin
          fails++;
          $display("FAIL wrap_down cyc %0d: got %b want %b", i, obs, expv());
        end
        if (m_tick) break;
      end
      vectors++;
      if (n == 0 && {Tens_Counter, Ones_Counter, Wrap} !== {4'd9, 4'd9, 1'b1}) begin
        fails++;
        $display("FAIL wrap_down_99: got %0d%0d w%b want 99 w1", Tens_Counter, Ones_Counter, Wrap);
      end
      if (n == 1 && {Tens_Counter, Ones_Counter, Wrap} !== {4'd9, 4'd8, 1'b0}) begin
        fails++;
        $display("FAIL wrap_down_98: got %0d%0d w%b want 98 w0", Tens_Counter, Ones_Counter, Wrap);
      end
    end
  endtask

  task automatic test_load_clear();
    Load = 1'b1; Load_Ones = 4'd12; Load_Tens = 4'd15;
    step();
    vectors++;
    if ({Tens_Counter, Ones_Counter} !== {4'd9, 4'd9}) begin
      fails++;
      $display("FAIL load_clamp: got %0d%0d want 99", Tens_Counter, Ones_Counter);
    end
    Clear = 1'b1; Load_Ones = 4'd5; Load_Tens = 4'd3;
    step();
    Clear = 1'b0;
    vectors++;
    if (obs !== expv() || {Tens_Counter, Ones_Counter} !== 8'h00) begin
      fails++;
      $display("FAIL clear_over_load: got %b want %b", obs, expv());
    end
    Load = 1'b0; Up_Down = 1'b1;
    for (int i = 0; i < 2 * DIV && m_pre != DIV - 1; i++) step();
    Load = 1'b1; Load_Ones = 4'd7; Load_Tens = 4'd4;
    step();
    Load = 1'b0;
    vectors++;
    if ({Tens_Counter, Ones_Counter, Tick} !== {4'd4, 4'd7, 1'b0} || obs !== expv()) begin
      fails++;
      $display("FAIL load_on_tick: got %0d%0d t%b want 47 t0", Tens_Counter, Ones_Counter, Tick);
    end
  endtask

  task automatic test_enable_hold();
    logic [7:0] held;
    for (int i = 0; i < 2; i++) step();
    held = {Tens_Counter, Ones_Counter};
    Enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (obs !== expv() || {Tens_Counter, Ones_Counter} !== held) begin
        fails++;
        $display("FAIL enable_hold cyc %0d: got %b want %b", i, obs, expv());
      end
    end
    Enable = 1'b1;
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      vectors++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL enable_resume cyc %0d: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_async_reset();
    Load = 1'b1; Load_Ones = 4'd6; Load_Tens = 4'd6;
    step();
    Load = 1'b0;
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 11'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want %b", obs, 11'd0);
    end
    m_cnt = 0; m_pre = 0; m_scan = 0; m_tick = 0; m_wrap = 0;
    step();
    Reset_n = 1'b1;
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      step();
      vectors++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, expv());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Enable    = ($urandom_range(0, 9) != 0);
      Up_Down   = $urandom_range(0, 1);
      Clear     = ($urandom_range(0, 39) == 0);
      Load      = ($urandom_range(0, 19) == 0);
      Load_Ones = 4'($urandom_range(0, 15));
      Load_Tens = 4'($urandom_range(0, 15));
      step();
      vectors++;
      if (obs !== expv() || Ones_Counter > 4'd9 || Tens_Counter > 4'd9) begin
        fails++;
        $display("FAIL random cyc %0d: got %b want %b", i, obs, expv());
      end
    end
    Clear = 1'b0; Load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_load_clear();
    test_enable_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
